uart_rx_os: RTL

Parametrised oversampling UART receiver: next generation of the fixed 8N1 receive path. Generates its own sample tick from the system clock, synchronises the asynchronous `rx` line, and decodes frames of configurable data width, parity and stop bits. Sits between the board RX pin and any byte consumer, reporting each frame with a one-cycle valid strobe plus parity and framing error flags.

---
 rtl/uart_rx_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_rx_os.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receive path.
//
// Contents:
//   St*       FSM state encoding (plain constants so older tools can consume them)
//   PAR_*     parity-mode selector values for PARITY_MODE
//   clog2     counter width helper, never returns less than 1
package uart_rx_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;
    localparam logic [2:0] StBreak  = 3'd5;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Ceiling log2, clamped to 1 so it can size a register holding 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: free-running divider that pulses `tick` for one
// clock every CLK_DIV system clocks (at the counter's terminal count).
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-low
//   tick   out  one-clock pulse every CLK_DIV clocks
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLK_DIV = 1 the counter sits at 0 and tick stays high every clock.
    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable data width, parity and stop
// bits. The asynchronous line is synchronised, sampled on an internal tick
// (CLK_DIV clocks) and each bit spans OVERSAMPLE ticks.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   -> every bit value is the 2-of-3 vote of the ticks mid-1, mid,
//                mid+1; the decision is taken on the mid+1 tick
//   undefined -> single sample at mid
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low
//   rx          in   asynchronous serial line, idle high
//   rx_data     out  last received word (LSB first on the line)
//   rx_done     out  one-clock strobe, rx_data and error flags valid
//   parity_err  out  parity mismatch of the last frame
//   frame_err   out  a stop bit of the last frame was sampled low
//   busy        out  high from start detection until back in idle
module uart_rx_os
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MajEn = 1;
`else
    localparam int unsigned MajEn = 0;
`endif

    localparam int unsigned OsW  = clog2(OVERSAMPLE);
    localparam int unsigned BitW = clog2(DATA_BITS);

    localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
    // Decision ticks. With voting the decision slips one tick past the centre
    // sample; for data/parity/stop that tick is os_cnt = 0 of the wrapped
    // counter, so the counter restarts at 1 to keep bit boundaries in place.
    localparam logic [OsW-1:0] StartDec = OsW'(OVERSAMPLE / 2 - 1 + MajEn);
    localparam logic [OsW-1:0] BitDec   = (MajEn != 0) ? '0 : OsLast;
    localparam logic [OsW-1:0] OsAfter  = OsW'(MajEn);

    localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
    localparam logic            StopLast = (STOP_BITS == 2);
    localparam logic            ParOdd   = (PARITY_MODE == PAR_ODD);
    localparam logic            ParUsed  = (PARITY_MODE != PAR_NONE);

    logic tick;

    logic                 rx_meta_q;
    logic                 rxs_q;
    logic [2:0]           state_q,      state_d;
    logic [OsW-1:0]       os_cnt_q,     os_cnt_d;
    logic [BitW-1:0]      bit_cnt_q,    bit_cnt_d;
    logic                 stop_cnt_q,   stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 par_bit_q,    par_bit_d;
    logic                 stop_err_q,   stop_err_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_done_q,    rx_done_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;

    logic bit_val;
    logic start_dec;
    logic bit_dec;
    logic stop_bad;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    // Line value on the two previous ticks; combined with the current sample
    // this gives the three votes at the decision tick.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[0], rxs_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
    assign bit_val = rxs_q;
`endif

    assign start_dec = (os_cnt_q == StartDec);
    assign bit_dec   = (os_cnt_q == BitDec);
    assign stop_bad  = stop_err_q | ~bit_val;

    always_comb begin
        state_d      = state_q;
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop_err_d   = stop_err_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (tick) begin
            if (os_cnt_q == OsLast) begin
                os_cnt_d = '0;
            end else begin
                os_cnt_d = os_cnt_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    os_cnt_d = '0;
                    if (!rxs_q) begin
                        state_d    = StStart;
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        stop_err_d = 1'b0;
                    end
                end

                StStart: begin
                    if (start_dec) begin
                        os_cnt_d = OsAfter;
                        // A high line at the start-bit centre was a glitch.
                        state_d  = bit_val ? StIdle : StData;
                    end
                end

                StData: begin
                    if (bit_dec) begin
                        os_cnt_d           = OsAfter;
                        shift_d[bit_cnt_q] = bit_val;
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
                            state_d   = ParUsed ? StParity : StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end

                StParity: begin
                    if (bit_dec) begin
                        os_cnt_d  = OsAfter;
                        par_bit_d = bit_val;
                        state_d   = StStop;
                    end
                end

                StStop: begin
                    if (bit_dec) begin
                        os_cnt_d   = OsAfter;
                        stop_err_d = stop_bad;
                        if (stop_cnt_q == StopLast) begin
                            rx_done_d    = 1'b1;
                            rx_data_d    = shift_q;
                            parity_err_d = ParUsed & (par_bit_q ^ (^shift_q) ^ ParOdd);
                            frame_err_d  = stop_bad;
                            state_d      = stop_bad ? StBreak : StIdle;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end
                end

                StBreak: begin
                    // Hold off until the line recovers so a stuck-low line
                    // cannot start a stream of bogus frames.
                    os_cnt_d = '0;
                    if (rxs_q) begin
                        state_d = StIdle;
                    end
                end

                default: begin
                    state_d  = StIdle;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= StIdle;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop_err_q   <= stop_err_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != StIdle);

endmodule
